// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle controller and the datapath:
// opcode/zero flow in from IR and ALU, all control strobes flow out.
interface multicycle_ctrl_if #(
  parameter int OP_W = 6
);
  logic [OP_W-1:0] opcode;
  logic            zero;
  logic            PCWre;
  logic [1:0]      PCSrc;
  logic            IRWre;
  logic            ALUSrcA;
  logic            ALUSrcB;
  logic [2:0]      ALUOp;
  logic            ExtSel;
  logic            RegWre;
  logic [1:0]      RegDst;
  logic            WrRegDSrc;
  logic            DBDataSrc;
  logic            mRD;
  logic            mWR;
  logic [3:0]      state;

  // Controller side
  modport master (
    input  opcode, zero,
    output PCWre, PCSrc, IRWre, ALUSrcA, ALUSrcB, ALUOp, ExtSel,
           RegWre, RegDst, WrRegDSrc, DBDataSrc, mRD, mWR, state
  );

  // Datapath side
  modport slave (
    output opcode, zero,
    input  PCWre, PCSrc, IRWre, ALUSrcA, ALUSrcB, ALUOp, ExtSel,
           RegWre, RegDst, WrRegDSrc, DBDataSrc, mRD, mWR, state
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the MIPS-subset CPU. Sequences each
// instruction through IF/ID/EXE/MEM/WB; outputs are a combinational
// decode of the state register, the IR opcode and the ALU zero flag.
module multicycle_ctrl #(
  parameter int OP_W = 6
) (
  input logic               clk,
  input logic               reset,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_IF     = 4'd0,
    S_ID     = 4'd1,
    S_EXE_AL = 4'd2,
    S_EXE_B  = 4'd3,
    S_EXE_LS = 4'd4,
    S_MEM    = 4'd5,
    S_WB_AL  = 4'd6,
    S_WB_LD  = 4'd7,
    S_HALT   = 4'd8
  } state_t;

  typedef enum logic [3:0] {
    K_ALU, K_BR, K_LW, K_SW, K_J, K_JR, K_JAL, K_HALT, K_ILL
  } kind_t;

  localparam logic [OP_W-1:0] OP_ADD  = OP_W'('b000000);
  localparam logic [OP_W-1:0] OP_SUB  = OP_W'('b000001);
  localparam logic [OP_W-1:0] OP_ADDI = OP_W'('b000010);
  localparam logic [OP_W-1:0] OP_ORI  = OP_W'('b010000);
  localparam logic [OP_W-1:0] OP_AND  = OP_W'('b010001);
  localparam logic [OP_W-1:0] OP_OR   = OP_W'('b010010);
  localparam logic [OP_W-1:0] OP_SLL  = OP_W'('b011000);
  localparam logic [OP_W-1:0] OP_SLTI = OP_W'('b100110);
  localparam logic [OP_W-1:0] OP_SW   = OP_W'('b110000);
  localparam logic [OP_W-1:0] OP_LW   = OP_W'('b110001);
  localparam logic [OP_W-1:0] OP_BEQ  = OP_W'('b110100);
  localparam logic [OP_W-1:0] OP_BNE  = OP_W'('b110101);
  localparam logic [OP_W-1:0] OP_J    = OP_W'('b111000);
  localparam logic [OP_W-1:0] OP_JR   = OP_W'('b111001);
  localparam logic [OP_W-1:0] OP_JAL  = OP_W'('b111010);
  localparam logic [OP_W-1:0] OP_HALT = OP_W'('b111111);

  state_t     state_q, state_d;
  kind_t      kind;
  logic [2:0] dec_aluop;
  logic       dec_srca, dec_srcb, dec_ext, dec_wrsrc;
  logic [1:0] dec_regdst;
  logic       br_taken;
  logic       pcwre_c, irwre_c, regwre_c, mrd_c, mwr_c;

  // State register; reset parks the machine in IF
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_IF;
    else        state_q <= state_d;
  end

  // Opcode decode: instruction class plus the datapath selects it needs
  always_comb begin
    kind       = K_ILL;
    dec_aluop  = 3'b000;
    dec_srca   = 1'b0;
    dec_srcb   = 1'b0;
    dec_ext    = 1'b1;
    dec_regdst = 2'b00;
    dec_wrsrc  = 1'b1;
    case (bus.opcode)
      OP_ADD:  begin kind = K_ALU; dec_regdst = 2'b10; end
      OP_SUB:  begin kind = K_ALU; dec_aluop = 3'b001; dec_regdst = 2'b10; end
      OP_ADDI: begin kind = K_ALU; dec_srcb = 1'b1; dec_regdst = 2'b01; end
      OP_ORI:  begin
        kind = K_ALU; dec_aluop = 3'b011; dec_srcb = 1'b1;
        dec_ext = 1'b0; dec_regdst = 2'b01;
      end
      OP_AND:  begin kind = K_ALU; dec_aluop = 3'b100; dec_regdst = 2'b10; end
      OP_OR:   begin kind = K_ALU; dec_aluop = 3'b011; dec_regdst = 2'b10; end
      OP_SLL:  begin
        kind = K_ALU; dec_aluop = 3'b010; dec_srca = 1'b1; dec_regdst = 2'b10;
      end
      OP_SLTI: begin
        kind = K_ALU; dec_aluop = 3'b110; dec_srcb = 1'b1; dec_regdst = 2'b01;
      end
      OP_SW:   begin kind = K_SW; dec_srcb = 1'b1; end
      OP_LW:   begin kind = K_LW; dec_srcb = 1'b1; dec_regdst = 2'b01; end
      OP_BEQ:  begin kind = K_BR; dec_aluop = 3'b001; end
      OP_BNE:  begin kind = K_BR; dec_aluop = 3'b001; end
      OP_J:    kind = K_J;
      OP_JR:   kind = K_JR;
      OP_JAL:  begin kind = K_JAL; dec_wrsrc = 1'b0; end
      OP_HALT: kind = K_HALT;
      default: kind = K_ILL;
    endcase
  end

  assign br_taken = ((bus.opcode == OP_BEQ) &&  bus.zero) ||
                    ((bus.opcode == OP_BNE) && !bus.zero);

  // Next-state and control outputs; datapath selects only live from ID to WB
  always_comb begin
    state_d       = state_q;
    pcwre_c       = 1'b0;
    irwre_c       = 1'b0;
    regwre_c      = 1'b0;
    mrd_c         = 1'b0;
    mwr_c         = 1'b0;
    bus.PCSrc     = 2'b00;
    bus.DBDataSrc = 1'b0;
    bus.ALUOp     = 3'b000;
    bus.ALUSrcA   = 1'b0;
    bus.ALUSrcB   = 1'b0;
    bus.ExtSel    = 1'b0;
    bus.RegDst    = 2'b00;
    bus.WrRegDSrc = 1'b0;
    if (state_q inside {[S_ID:S_WB_LD]}) begin
      bus.ALUOp     = dec_aluop;
      bus.ALUSrcA   = dec_srca;
      bus.ALUSrcB   = dec_srcb;
      bus.ExtSel    = dec_ext;
      bus.RegDst    = dec_regdst;
      bus.WrRegDSrc = dec_wrsrc;
    end
    case (state_q)
      S_IF: begin
        irwre_c = 1'b1;
        state_d = S_ID;
      end
      S_ID: begin
        case (kind)
          K_J:    begin pcwre_c = 1'b1; bus.PCSrc = 2'b11; state_d = S_IF; end
          K_JR:   begin pcwre_c = 1'b1; bus.PCSrc = 2'b10; state_d = S_IF; end
          K_JAL:  begin
            pcwre_c = 1'b1; bus.PCSrc = 2'b11; regwre_c = 1'b1; state_d = S_IF;
          end
          K_HALT: state_d = S_HALT;
          K_BR:   state_d = S_EXE_B;
          K_LW:   state_d = S_EXE_LS;
          K_SW:   state_d = S_EXE_LS;
          K_ALU:  state_d = S_EXE_AL;
          default: begin pcwre_c = 1'b1; state_d = S_IF; end
        endcase
      end
      S_EXE_AL: state_d = S_WB_AL;
      S_WB_AL: begin
        regwre_c = 1'b1;
        pcwre_c  = 1'b1;
        state_d  = S_IF;
      end
      S_EXE_B: begin
        pcwre_c   = 1'b1;
        bus.PCSrc = br_taken ? 2'b01 : 2'b00;
        state_d   = S_IF;
      end
      S_EXE_LS: state_d = S_MEM;
      S_MEM: begin
        if (kind == K_LW) begin
          mrd_c   = 1'b1;
          state_d = S_WB_LD;
        end else begin
          mwr_c   = (kind == K_SW);
          pcwre_c = 1'b1;
          state_d = S_IF;
        end
      end
      S_WB_LD: begin
        mrd_c         = 1'b1;
        bus.DBDataSrc = 1'b1;
        regwre_c      = 1'b1;
        pcwre_c       = 1'b1;
        state_d       = S_IF;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IF;
    endcase
  end

  // Enables are held low for as long as reset is asserted, not just at the edge
  assign bus.PCWre  = pcwre_c  & reset;
  assign bus.IRWre  = irwre_c  & reset;
  assign bus.RegWre = regwre_c & reset;
  assign bus.mRD    = mrd_c    & reset;
  assign bus.mWR    = mwr_c    & reset;
  assign bus.state  = state_q;

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multi-cycle control FSM for the MIPS-subset CPU. It sequences each instruction through IF/ID/EXE/MEM/WB. It drives the PC write-enable (PCWre) and next-PC select consumed by the PC register, plus IR, register-file, ALU and data-memory controls. The opcode comes from the instruction register and the zero flag from the ALU.

Parameters:
OP_W, 6, opcode width

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low; 0 forces state IF
opcode  input  6  instruction opcode from IR, valid from ID onward
zero  input  1  ALU zero flag, valid in EXE_B
PCWre  output  1  PC write enable, one cycle per instruction
PCSrc  output  2  00 PC+4, 01 PC+4+(imm<<2), 10 jr register, 11 jump target
IRWre  output  1  IR load enable
ALUSrcA  output  1  1 = shamt, 0 = rs
ALUSrcB  output  1  1 = extended immediate, 0 = rt
ALUOp  output  3  000 add, 001 sub, 010 sll, 011 or, 100 and, 110 slt
ExtSel  output  1  1 = sign-extend, 0 = zero-extend
RegWre  output  1  register-file write enable
RegDst  output  2  00 = $31, 01 = rt, 10 = rd
WrRegDSrc  output  1  1 = ALU/memory data, 0 = PC+4
DBDataSrc  output  1  1 = memory read data, 0 = ALU result
mRD  output  1  data memory read
mWR  output  1  data memory write
state  output  4  current state (debug)

Behaviour:
- Clock and reset: one clock domain on clk. reset is asynchronous and active-low.
  - While reset = 0: state = IF (0), and all enables (PCWre, IRWre, RegWre, mRD, mWR) are forced to 0.
  - After release: IF is entered normally on the next edge.
- State encoding: IF 0, ID 1, EXE_AL 2, EXE_B 3, EXE_LS 4, MEM 5, WB_AL 6, WB_LD 7, HALT 8.
- Outputs are a combinational decode of state, opcode and zero. The state register is the only storage.
- Opcodes:
  - add 000000, sub 000001, addi 000010
  - ori 010000, and 010001, or 010010, sll 011000, slti 100110
  - sw 110000, lw 110001, beq 110100, bne 110101
  - j 111000, jr 111001, jal 111010, halt 111111
  - Any other opcode is illegal.
- State transitions and outputs:
  - IF: IRWre = 1; next state ID.
  - ID, opcode j: PCWre = 1, PCSrc = 11; next IF.
  - ID, opcode jr: PCWre = 1, PCSrc = 10; next IF.
  - ID, opcode jal: PCWre = 1, PCSrc = 11, RegWre = 1, RegDst = 00, WrRegDSrc = 0; next IF.
  - ID, opcode halt: next HALT.
  - ID, opcode beq/bne: next EXE_B.
  - ID, opcode lw/sw: next EXE_LS.
  - ID, ALU opcodes: next EXE_AL.
  - ID, illegal opcode: PCWre = 1, PCSrc = 00, no other writes; next IF.
  - EXE_AL: next WB_AL.
  - WB_AL: RegWre = 1, PCWre = 1, PCSrc = 00; next IF.
  - EXE_B: ALUOp = 001, PCWre = 1; next IF.
    - PCSrc = 01 if (beq and zero = 1) or (bne and zero = 0); otherwise 00.
  - EXE_LS: ALUOp = 000, ALUSrcB = 1, ExtSel = 1; next MEM.
  - MEM, sw: mWR = 1, PCWre = 1, PCSrc = 00; next IF.
  - MEM, lw: mRD = 1; next WB_LD.
  - WB_LD: mRD = 1, DBDataSrc = 1, RegWre = 1, RegDst = 01, PCWre = 1; next IF.
  - HALT: absorbing; all enables 0. Exit only via reset.
- Datapath decode (held from ID through WB):
  - ALUOp: add/addi/lw/sw 000; sub/beq/bne 001; sll 010; or/ori 011; and 100; slti 110.
  - ALUSrcA = 1 only for sll.
  - ALUSrcB = 1 for addi, ori, slti, lw, sw.
  - ExtSel = 0 only for ori.
  - RegDst: 01 for addi, ori, slti, lw; 10 for R-type; 00 for jal.
  - WrRegDSrc = 0 only for jal.
- Invariants:
  - PCWre is high in exactly one cycle per instruction, always the last cycle.
  - RegWre and mWR are never high in the same cycle.
  - Unless stated otherwise, every enable is 0 and every select is 0.
- Latency (cycles per instruction): j/jr/jal 2; beq/bne 3; sw 4; ALU ops 4; lw 5.

Test Plan:
1. Reset low for 3 cycles mid-EXE_AL -> state = 0 and PCWre/RegWre = 0 immediately (async); after release: IF (IRWre = 1), then ID.
2. Opcode add -> states 0,1,2,6; in state 6: RegWre = 1, RegDst = 10, ALUOp = 000, PCWre = 1, PCSrc = 00; PCWre high exactly 1 cycle of 4.
3. beq with zero = 1 -> state 3: PCWre = 1, PCSrc = 01; bne with zero = 1 -> PCSrc = 00; each takes 3 cycles.
4. lw -> states 0,1,4,5,7; mRD = 1 in 5 and 7; in 7: DBDataSrc = 1, RegDst = 01, RegWre = 1. sw -> mWR = 1 only in state 5, RegWre = 0 throughout.
5. jal -> in ID: RegWre = 1, RegDst = 00, WrRegDSrc = 0, PCSrc = 11, PCWre = 1; next state IF. jr -> PCSrc = 10.
6. halt -> state 8 held for 20 cycles with all enables 0; illegal opcode 101010 -> PC+4 (PCSrc = 00) in ID with no other writes.
